parking_gate_ctrl: RTL and testbench

- Occupancy controller for a single-lane lot gate with two beam sensors: `sens_a` is on the outside and `sens_b` is on the inside.
- Decodes the ordered a/b beam-break sequence into enter and exit events.
- Sequences the occupancy up/down count and saturates it at 0 and at CAPACITY.
- Drives full/empty flags and one-cycle event pulses to the display and gate logic.

---
 rtl/parking_gate_ctrl.sv | 164 ++++++++++++++++
 tb/tb_parking_gate_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl: occupancy controller for a single-lane lot gate.
// Two beam sensors (a = outside, b = inside) are synchronized. A small FSM
// decodes the ordered beam-break sequence into enter/exit events, and those
// events drive a saturating occupancy counter.
// Optional build macro: PARKING_GATE_TIMEOUT_EN aborts a partial sequence
// that stays in one state for TIMEOUT cycles.
module parking_gate_ctrl #(
    parameter int CW       = 4,
    parameter int CAPACITY = 15,
    parameter int TIMEOUT  = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          sens_a,
    input  logic          sens_b,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          enter_pulse,
    output logic          exit_pulse,
    output logic          err_pulse
);
    typedef enum logic [2:0] {IDLE, E1, E2, E3, X1, X2, X3, BAD} state_t;

    localparam logic [CW-1:0] CAP = CW'(CAPACITY);

    // Reject parameter sets that could never be met: the count must be able to reach CAPACITY.
    if ((CAPACITY > (2 ** CW) - 1) || (TIMEOUT < 1)) begin : g_param_check
        $error("parking_gate_ctrl: CAPACITY must fit in CW bits and TIMEOUT must be >= 1");
    end

    logic          r_a_meta, r_a_sync, r_b_meta, r_b_sync;
    state_t        r_state;
    logic [CW-1:0] r_count;
    logic          r_enter_pulse, r_exit_pulse, r_err_pulse;

    logic [1:0]    w_ab;
    state_t        w_state_next;
    logic          w_enter_evt, w_exit_evt, w_seq_err;
    logic          w_overflow, w_underflow;

    assign w_ab = {r_a_sync, r_b_sync};

`ifdef PARKING_GATE_TIMEOUT_EN
    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] r_timer;
    logic          w_partial;

    assign w_partial = (r_state != IDLE) && (r_state != BAD);

    // Dwell timer: counts cycles in the current partial state and clears on any state change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timer <= '0;
        end else if (!w_partial || (w_state_next != r_state)) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + TW'(1);
        end
    end
`endif

    // Next-state decode of the synchronized beam pair and event/error detection.
    always_comb begin
        w_state_next = r_state;
        w_enter_evt  = 1'b0;
        w_exit_evt   = 1'b0;
        w_seq_err    = 1'b0;
        case (r_state)
            IDLE: case (w_ab)
                2'b10:   w_state_next = E1;
                2'b01:   w_state_next = X1;
                2'b11:   begin w_state_next = BAD; w_seq_err = 1'b1; end
                default: w_state_next = IDLE;
            endcase
            E1: case (w_ab)
                2'b11:   w_state_next = E2;
                2'b00:   w_state_next = IDLE;
                2'b01:   begin w_state_next = BAD; w_seq_err = 1'b1; end
                default: w_state_next = E1;
            endcase
            E2: case (w_ab)
                2'b01:   w_state_next = E3;
                2'b10:   w_state_next = E1;
                2'b00:   begin w_state_next = BAD; w_seq_err = 1'b1; end
                default: w_state_next = E2;
            endcase
            E3: case (w_ab)
                2'b00:   begin w_state_next = IDLE; w_enter_evt = 1'b1; end
                2'b11:   w_state_next = E2;
                2'b10:   begin w_state_next = BAD; w_seq_err = 1'b1; end
                default: w_state_next = E3;
            endcase
            X1: case (w_ab)
                2'b11:   w_state_next = X2;
                2'b00:   w_state_next = IDLE;
                2'b10:   begin w_state_next = BAD; w_seq_err = 1'b1; end
                default: w_state_next = X1;
            endcase
            X2: case (w_ab)
                2'b10:   w_state_next = X3;
                2'b01:   w_state_next = X1;
                2'b00:   begin w_state_next = BAD; w_seq_err = 1'b1; end
                default: w_state_next = X2;
            endcase
            X3: case (w_ab)
                2'b00:   begin w_state_next = IDLE; w_exit_evt = 1'b1; end
                2'b11:   w_state_next = X2;
                2'b01:   begin w_state_next = BAD; w_seq_err = 1'b1; end
                default: w_state_next = X3;
            endcase
            BAD:     w_state_next = (w_ab == 2'b00) ? IDLE : BAD;
            default: w_state_next = IDLE;
        endcase
`ifdef PARKING_GATE_TIMEOUT_EN
        // A partial sequence that would dwell past its budget is abandoned.
        if (w_partial && (w_state_next == r_state) && (r_timer == TMR_LAST)) begin
            w_state_next = BAD;
            w_seq_err    = 1'b1;
        end
`endif
    end

    assign w_overflow  = w_enter_evt && (r_count == CAP);
    assign w_underflow = w_exit_evt && (r_count == '0);

    // Synchronizers, FSM state, saturating occupancy count and registered pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a_meta      <= 1'b0;
            r_a_sync      <= 1'b0;
            r_b_meta      <= 1'b0;
            r_b_sync      <= 1'b0;
            r_state       <= IDLE;
            r_count       <= '0;
            r_enter_pulse <= 1'b0;
            r_exit_pulse  <= 1'b0;
            r_err_pulse   <= 1'b0;
        end else begin
            r_a_meta      <= sens_a;
            r_a_sync      <= r_a_meta;
            r_b_meta      <= sens_b;
            r_b_sync      <= r_b_meta;
            r_state       <= w_state_next;
            r_enter_pulse <= w_enter_evt;
            r_exit_pulse  <= w_exit_evt;
            r_err_pulse   <= w_seq_err | w_overflow | w_underflow;
            if (w_enter_evt && !w_overflow) begin
                r_count <= r_count + CW'(1);
            end else if (w_exit_evt && !w_underflow) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    assign count       = r_count;
    assign full        = (r_count == CAP);
    assign empty       = (r_count == '0);
    assign enter_pulse = r_enter_pulse;
    assign exit_pulse  = r_exit_pulse;
    assign err_pulse   = r_err_pulse;
endmodule

// File: tb/tb_parking_gate_ctrl.sv
// tb_parking_gate_ctrl: scoreboard bench for the lot gate controller.
// Each beam sequence pushes its expected pulse totals and final count;
// after the sequence settles the record is popped and compared.
`timescale 1ns/1ps
module tb_parking_gate_ctrl;
    localparam int CW       = 4;
    localparam int CAPACITY = 15;
    localparam int TIMEOUT  = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          sens_a, sens_b;
    logic [CW-1:0] count;
    logic          full, empty, enter_pulse, exit_pulse, err_pulse;

    parking_gate_ctrl #(.CW(CW), .CAPACITY(CAPACITY), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .sens_a      (sens_a),
        .sens_b      (sens_b),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .enter_pulse (enter_pulse),
        .exit_pulse  (exit_pulse),
        .err_pulse   (err_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    n_en;
        int    n_ex;
        int    n_err;
        int    cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   mon_en, mon_ex, mon_err;
    int   exp_cnt;
    int   to_err;

    task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // One clock: sample on the falling edge and accumulate pulses.
    task automatic tick();
        @(negedge clk);
        mon_en  += int'(enter_pulse);
        mon_ex  += int'(exit_pulse);
        mon_err += int'(err_pulse);
        check_eq("excl", {31'b0, enter_pulse & exit_pulse}, 32'd0);
    endtask

    task automatic hold(input logic [1:0] ab, input int cycles);
        {sens_a, sens_b} = ab;
        repeat (cycles) tick();
    endtask

    task automatic run_seq(input string tag, input logic [15:0] pat, input int n, input int hcyc,
                           input int e_en, input int e_ex, input int e_err);
        exp_t       e;
        exp_t       got;
        logic [1:0] ab;
        e.tag = tag; e.n_en = e_en; e.n_ex = e_ex; e.n_err = e_err; e.cnt = exp_cnt;
        exp_q.push_back(e);
        mon_en = 0; mon_ex = 0; mon_err = 0;
        for (int i = 0; i < n; i++) begin
            ab = pat[15-2*i -: 2];
            hold(ab, hcyc);
        end
        repeat (4) tick();
        got = exp_q.pop_front();
        check_eq({got.tag, "/enter"}, mon_en, got.n_en);
        check_eq({got.tag, "/exit"},  mon_ex, got.n_ex);
        check_eq({got.tag, "/err"},   mon_err, got.n_err);
        check_eq({got.tag, "/count"}, {28'b0, count}, got.cnt);
        check_eq({got.tag, "/full"},  {31'b0, full},  (got.cnt == CAPACITY) ? 1 : 0);
        check_eq({got.tag, "/empty"}, {31'b0, empty}, (got.cnt == 0) ? 1 : 0);
        $display("seq %-12s enter=%0d exit=%0d err=%0d count=%0d", got.tag, mon_en, mon_ex, mon_err, count);
    endtask

    task automatic do_enter();
        int err;
        err = (exp_cnt == CAPACITY) ? 1 : 0;
        if (exp_cnt < CAPACITY) exp_cnt++;
        run_seq("enter", 16'b10_11_01_00_00000000, 4, 4, 1, 0, err);
    endtask

    task automatic do_exit();
        int err;
        err = (exp_cnt == 0) ? 1 : 0;
        if (exp_cnt > 0) exp_cnt--;
        run_seq("exit", 16'b01_11_10_00_00000000, 4, 4, 0, 1, err);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; sens_a = 1'b0; sens_b = 1'b0; exp_cnt = 0;
        mon_en = 0; mon_ex = 0; mon_err = 0;
        repeat (3) @(negedge clk);
        check_eq("rst/count", {28'b0, count}, 32'd0);
        check_eq("rst/empty", {31'b0, empty}, 32'd1);
        check_eq("rst/full",  {31'b0, full},  32'd0);
        check_eq("rst/pulses", {29'b0, enter_pulse, exit_pulse, err_pulse}, 32'd0);
        reset = 1'b0;

        // Clean enter with exact latency: pulse on the 3rd edge after raw 00.
        hold(2'b00, 4); hold(2'b10, 4); hold(2'b11, 4); hold(2'b01, 4);
        {sens_a, sens_b} = 2'b00;
        tick(); tick();
        check_eq("lat2/enter", {31'b0, enter_pulse}, 32'd0);
        check_eq("lat2/count", {28'b0, count}, 32'd0);
        check_eq("lat2/empty", {31'b0, empty}, 32'd1);
        tick();
        check_eq("lat3/enter", {31'b0, enter_pulse}, 32'd1);
        check_eq("lat3/count", {28'b0, count}, 32'd1);
        check_eq("lat3/empty", {31'b0, empty}, 32'd0);
        tick();
        check_eq("lat4/enter", {31'b0, enter_pulse}, 32'd0);
        exp_cnt = 1;
        $display("seq enter_lat   count=%0d", count);

        do_enter(); do_enter();            // count 3
        do_exit();                         // count 2, no error
        do_exit(); do_exit();              // count 0
        do_exit();                         // underflow
        repeat (5) do_enter();             // count 5

        // Asynchronous reset while in E2.
        hold(2'b10, 4); hold(2'b11, 4);
        #2 reset = 1'b1;
        #1;
        check_eq("arst/count", {28'b0, count}, 32'd0);
        check_eq("arst/empty", {31'b0, empty}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_cnt = 0;
        run_seq("rst_release", 16'b01_00_000000000000, 2, 4, 0, 0, 0);

        repeat (15) do_enter();            // count 15, full
        do_enter();                        // overflow
        run_seq("backout", 16'b10_11_10_00_00000000, 4, 4, 0, 0, 0);
        run_seq("bad_seq", 16'b10_01_11_10_00_000000, 5, 4, 0, 0, 1);
        run_seq("idle_11", 16'b11_00_000000000000, 2, 4, 0, 0, 1);
        do_exit();                         // count 14

`ifdef PARKING_GATE_TIMEOUT_EN
        to_err = 1;
`else
        to_err = 0;
`endif
        run_seq("hold_10", 16'b10_00_000000000000, 2, 20, 0, 0, to_err);
        do_enter();                        // count 15
        do_exit();                         // count 14

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
